// File: rtl/sipo_pkg.sv
// Shared types and helpers for the serial-to-parallel deserializer.
// SIPO_PARITY_EN adds the PARITY state and a trailing even-parity bit per frame.
package sipo_pkg;

`ifdef SIPO_PARITY_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;
  localparam int PARITY_BITS = 1;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
  } state_t;
  localparam int PARITY_BITS = 0;
`endif

  // A counter must hold the values 0 .. frame_len-1.
  function automatic int ctr_width(input int frame_len);
    return (frame_len < 2) ? 1 : $clog2(frame_len);
  endfunction

endpackage

// File: rtl/sipo_bit_ctr.sv
// Frame bit counter: counts sampled bits and flags the last bit of a frame.
module sipo_bit_ctr #(
  parameter int LAST = 7,
  parameter int CW   = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clear,
  input  logic          i_en,
  output logic [CW-1:0] o_count,
  output logic          o_tc
);

  localparam logic [CW-1:0] LAST_C = CW'(LAST);

  logic [CW-1:0] r_count;

  assign o_tc    = (r_count == LAST_C);
  assign o_count = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_en) begin
      if (o_tc) r_count <= '0;
      else      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/sipo_deser.sv
// Serial-in parallel-out deserializer with valid/ready output and sticky overrun.
// Build option SIPO_PARITY_EN: frame gains an even-parity bit and a parity_err output.
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int LSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             data_in,
  input  logic             shift_en,
  input  logic             clear,
  input  logic             ready,
  output logic [WIDTH-1:0] q,
  output logic             valid,
  output logic             busy,
  output logic             overrun,
`ifdef SIPO_PARITY_EN
  output logic             parity_err,
`endif
  output logic [1:0]       o_dbg_state
);

  // Output handshake: q is offered while valid=1 and is taken on any rising
  // edge where valid && ready; a word completing on that edge replaces it.
  localparam int FRAME_LEN = WIDTH + PARITY_BITS;
  localparam int CW        = ctr_width(FRAME_LEN);

  state_t           r_state;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] r_q;
  logic             r_valid;
  logic             r_overrun;

  logic [CW-1:0]    w_count;
  logic             w_tc;
  logic             w_shift;
  logic             w_sr_shift;
  logic             w_done;
  logic [WIDTH-1:0] w_sr_next;
  logic [WIDTH-1:0] w_word;

  assign w_shift = shift_en & ~clear;
  assign w_done  = w_shift & w_tc;

  always_comb begin
    if (LSB_FIRST != 0) w_sr_next = {data_in, r_sr[WIDTH-1:1]};
    else                w_sr_next = {r_sr[WIDTH-2:0], data_in};
  end

`ifdef SIPO_PARITY_EN
  localparam logic [CW-1:0] LAST_DATA = CW'(WIDTH-1);
  logic r_perr;
  logic w_perr;
  // The parity bit is never shifted into the data register.
  assign w_sr_shift = w_shift & (r_state != PARITY);
  assign w_word     = r_sr;
  assign w_perr     = ^{r_sr, data_in};
  assign parity_err = r_perr;
`else
  assign w_sr_shift = w_shift;
  assign w_word     = w_sr_next;
`endif

  sipo_bit_ctr #(
    .LAST (FRAME_LEN - 1),
    .CW   (CW)
  ) u_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (clear),
    .i_en    (shift_en),
    .o_count (w_count),
    .o_tc    (w_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_sr      <= '0;
      r_q       <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
`ifdef SIPO_PARITY_EN
      r_perr    <= 1'b0;
`endif
    end else if (clear) begin
      r_state   <= IDLE;
      r_sr      <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
`ifdef SIPO_PARITY_EN
      r_perr    <= 1'b0;
`endif
    end else begin
      if (w_sr_shift) r_sr <= w_sr_next;
      if (w_shift) begin
        if (w_tc) r_state <= IDLE;
`ifdef SIPO_PARITY_EN
        else if (w_count == LAST_DATA) r_state <= PARITY;
`endif
        else r_state <= SHIFT;
      end
      if (w_done) begin
        r_q     <= w_word;
        r_valid <= 1'b1;
`ifdef SIPO_PARITY_EN
        r_perr  <= w_perr;
`endif
        if (r_valid && !ready) r_overrun <= 1'b1;
      end else if (r_valid && ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign q           = r_q;
  assign valid       = r_valid;
  assign overrun     = r_overrun;
  assign busy        = (w_count != '0);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_sipo_deser.sv
// Self-checking bench for sipo_deser: LSB-first and MSB-first instances share stimulus.
// Honours SIPO_PARITY_EN when defined for the build.
module tb_sipo_deser;

  localparam int W = 8;
`ifdef SIPO_PARITY_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif

  // clock / reset
  logic clk      = 1'b0;
  logic rst_n    = 1'b1;
  logic data_in  = 1'b0;
  logic shift_en = 1'b0;
  logic clear    = 1'b0;
  logic ready    = 1'b0;

  logic [W-1:0] q_l, q_m;
  logic         valid_l, valid_m, busy_l, busy_m, ovr_l, ovr_m;
  logic [1:0]   st_l, st_m;
`ifdef SIPO_PARITY_EN
  logic         pe_l, pe_m;
`endif

  always #5 clk = ~clk;

  sipo_deser #(.WIDTH(W), .LSB_FIRST(1)) dut_l (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .shift_en(shift_en),
    .clear(clear), .ready(ready), .q(q_l), .valid(valid_l), .busy(busy_l),
    .overrun(ovr_l),
`ifdef SIPO_PARITY_EN
    .parity_err(pe_l),
`endif
    .o_dbg_state(st_l)
  );

  sipo_deser #(.WIDTH(W), .LSB_FIRST(0)) dut_m (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .shift_en(shift_en),
    .clear(clear), .ready(ready), .q(q_m), .valid(valid_m), .busy(busy_m),
    .overrun(ovr_m),
`ifdef SIPO_PARITY_EN
    .parity_err(pe_m),
`endif
    .o_dbg_state(st_m)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // scoreboard state: expected words awaiting consumption, bits of the open frame
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_m_q[$];
  logic         exp_pe_q[$];
  bit           bits_q[$];
  bit           exp_ovr  = 1'b0;
  bit           rand_rdy = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model and monitor. Evaluated half a cycle before each rising
  // edge, so flags reflect the previous edge and inputs are those of the next.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bits_q.delete();
      exp_q.delete();
      exp_m_q.delete();
      exp_pe_q.delete();
      exp_ovr = 1'b0;
    end else begin
      chk("valid_l", valid_l, exp_q.size() != 0);
      chk("valid_m", valid_m, exp_q.size() != 0);
      chk("busy_l", busy_l, bits_q.size() != 0);
      chk("busy_m", busy_m, bits_q.size() != 0);
      chk("overrun_l", ovr_l, exp_ovr);
      chk("overrun_m", ovr_m, exp_ovr);
      if (exp_q.size() != 0 && ready) begin
        chk("q_lsb", q_l, exp_q.pop_front());
        chk("q_msb", q_m, exp_m_q.pop_front());
`ifdef SIPO_PARITY_EN
        chk("parity_err", pe_l, exp_pe_q[0]);
        chk("parity_err_m", pe_m, exp_pe_q.pop_front());
`else
        void'(exp_pe_q.pop_front());
`endif
      end
      if (clear) begin
        bits_q.delete();
        exp_q.delete();
        exp_m_q.delete();
        exp_pe_q.delete();
        exp_ovr = 1'b0;
      end else if (shift_en) begin
        bits_q.push_back(data_in);
        if (bits_q.size() == FRAME) begin
          logic [W-1:0] wl, wm;
          logic         pe;
          wl = '0;
          wm = '0;
          pe = 1'b0;
          for (int i = 0; i < W; i++) begin
            wl[i]       = bits_q[i];
            wm[W-1-i]   = bits_q[i];
          end
          for (int i = 0; i < FRAME; i++) pe = pe ^ bits_q[i];
          if (exp_q.size() != 0) begin
            void'(exp_q.pop_back());
            void'(exp_m_q.pop_back());
            void'(exp_pe_q.pop_back());
            exp_ovr = 1'b1;
          end
          exp_q.push_back(wl);
          exp_m_q.push_back(wm);
          exp_pe_q.push_back(pe);
          bits_q.delete();
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) ready = 1'($urandom_range(0, 1));
  endtask

  task automatic gap(input int n);
    repeat (n) tick();
  endtask

  task automatic send_bit(input bit b);
    shift_en = 1'b1;
    data_in  = b;
    tick();
    shift_en = 1'b0;
    data_in  = 1'b0;
  endtask

  // Sends w LSB-first in time; parity bit (if present) is even parity xor bad_par.
  task automatic send_frame(input logic [W-1:0] w, input int max_gap,
                            input bit bad_par, input int rdy_last);
    for (int i = 0; i < FRAME; i++) begin
      bit b;
      b = (i < W) ? w[i] : ((^w) ^ bad_par);
      if (i == FRAME - 1 && rdy_last >= 0) ready = rdy_last[0];
      send_bit(b);
      if (i < FRAME - 1) gap($urandom_range(0, max_gap));
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_q_l"}, q_l, 0);
    chk({tag, "_q_m"}, q_m, 0);
    chk({tag, "_valid"}, valid_l, 0);
    chk({tag, "_busy"}, busy_l, 0);
    chk({tag, "_overrun"}, ovr_l, 0);
    chk({tag, "_state"}, st_l, 0);
  endtask

  initial begin
    logic [W-1:0] w;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_zero("reset");
    rst_n = 1'b1;
    ready = 1'b1;
    tick();

    // bit pattern 1,0,0,1,1,0,0,1
    send_frame(8'h99, 0, 1'b0, -1);
    chk("d_99_q", q_l, 8'h99);
    chk("d_99_valid", valid_l, 1);
    tick();

    // single leading one: position depends on bit order
    send_frame(8'h01, 0, 1'b0, -1);
    chk("d_01_lsb", q_l, 8'h01);
    chk("d_01_msb", q_m, 8'h80);
    tick();

    // overrun with no consumer, then sticky, then clear
    ready = 1'b0;
    send_frame(8'h99, 0, 1'b0, -1);
    send_frame(8'h0F, 0, 1'b0, -1);
    chk("ovr_q", q_l, 8'h0F);
    chk("ovr_valid", valid_l, 1);
    chk("ovr_set", ovr_l, 1);
    gap(3);
    chk("ovr_sticky", ovr_l, 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_valid", valid_l, 0);
    chk("clr_overrun", ovr_l, 0);

    // consumer accepts on the same edge the next word completes
    send_frame(8'h99, 0, 1'b0, -1);
    send_frame(8'h0F, 0, 1'b0, 1);
    chk("same_edge_q", q_l, 8'h0F);
    chk("same_edge_valid", valid_l, 1);
    chk("same_edge_ovr", ovr_l, 0);
    tick();
    chk("consumed_valid", valid_l, 0);

    // abort a partial frame, then a gapped frame
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    chk("partial_busy", busy_l, 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("abort_busy", busy_l, 0);
    send_frame(8'hA5, 5, 1'b0, -1);
    chk("gap_a5_q", q_l, 8'hA5);
    chk("gap_a5_busy", busy_l, 0);
    tick();

    // asynchronous reset mid-frame
    for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)));
    rst_n = 1'b0;
    #2 chk_zero("mid_reset");
    rst_n = 1'b1;
    send_frame(8'h3C, 0, 1'b0, -1);
    chk("after_reset_q", q_l, 8'h3C);
    tick();

`ifdef SIPO_PARITY_EN
    send_frame(8'h99, 0, 1'b1, -1);
    chk("parity_bad", pe_l, 1);
    tick();
    send_frame(8'h99, 0, 1'b0, -1);
    chk("parity_good", pe_l, 0);
    tick();
`endif

    // randomized traffic with a random consumer and occasional aborts
    rand_rdy = 1'b1;
    repeat (200) begin
      if ($urandom_range(0, 19) == 0) begin
        repeat ($urandom_range(1, FRAME - 1)) send_bit(1'($urandom_range(0, 1)));
        clear = 1'b1;
        tick();
        clear = 1'b0;
      end
      w = W'($urandom);
      send_frame(w, 3, 1'($urandom_range(0, 1)), -1);
      gap($urandom_range(0, 2));
    end
    rand_rdy = 1'b0;
    ready = 1'b1;
    gap(4);
    chk("drain_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sipo_deser.md
SIPO_DESER -- requirements
Module: sipo_deser

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning parallel word width in bits (legal 2..64).
REQ-002 The block SHALL have parameter LSB_FIRST, default 1, meaning the first serial bit lands in q[0] (1) or in q[WIDTH-1] (0).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port data_in, input, 1 bit: serial data.
REQ-006 The block SHALL have port shift_en, input, 1 bit: data_in is sampled on this edge.
REQ-007 The block SHALL have port clear, input, 1 bit: synchronous abort and flag clear.
REQ-008 The block SHALL have port q, output, WIDTH bits: the completed parallel word.
REQ-009 The block SHALL have port valid, output, 1 bit: q holds an unconsumed word.
REQ-010 The block SHALL have port ready, input, 1 bit: the consumer accepts q when valid && ready.
REQ-011 The block SHALL have port busy, output, 1 bit: a partial frame is in progress.
REQ-012 The block SHALL have port overrun, output, 1 bit: sticky flag, an unconsumed word was overwritten.

Function
REQ-013 The FSM SHALL have states IDLE (0 bits held), SHIFT (1..WIDTH-1 bits held) and, with the macro, PARITY (WIDTH data bits held, awaiting the parity bit).
REQ-014 On a clk edge with shift_en=1 and clear=0, the block SHALL sample data_in, shift the internal register and increment the bit counter; with shift_en=0 all state SHALL hold.
REQ-015 Shift direction: LSB_FIRST=1 SHALL shift right with the new bit entering the MSB; LSB_FIRST=0 SHALL shift left with the new bit entering bit 0.
REQ-016 On the edge that samples the final frame bit, the block SHALL load q, assert valid, zero the counter and return to IDLE; q SHALL be visible the cycle after that edge (zero added latency).
REQ-017 q SHALL remain stable while valid=1 unless overwritten per REQ-019.
REQ-018 valid SHALL deassert on an edge where valid && ready, unless a frame completes on that same edge, in which case the new word SHALL load, valid SHALL stay 1, and overrun SHALL NOT be set.
REQ-019 When a frame completes with valid=1 and ready=0, q SHALL be overwritten, valid SHALL stay 1, and overrun SHALL be set.
REQ-020 overrun SHALL remain set until clear or reset.
REQ-021 busy SHALL equal (counter != 0), registered with the counter.
REQ-022 clear=1 SHALL, on the edge, zero the counter and shift register, deassert valid and overrun, and enter IDLE; clear SHALL have priority over shift_en and ready.
REQ-023 The counter SHALL never exceed the frame length minus 1; wrap to 0 occurs only at frame completion.

Reset
REQ-024 While rst_n=0 the block SHALL asynchronously force q=0, valid=0, busy=0, overrun=0, counter=0 and state=IDLE; a reset mid-frame SHALL discard the partial bits.
REQ-025 The block SHALL leave reset synchronously: the first sample occurs on the first clk edge with rst_n=1 and shift_en=1.

Configuration
REQ-026 The macro SIPO_PARITY_EN SHALL, when defined, make the frame WIDTH+1 bits (the last bit is even parity) and add output parity_err (1 bit), updated with q at frame completion (1 = mismatch), cleared by clear and reset.
REQ-027 Without SIPO_PARITY_EN, the frame SHALL be WIDTH bits, the PARITY state SHALL be absent, and parity_err SHALL NOT exist.

Structure
REQ-028 The shared package sipo_pkg SHALL hold the state enum typedef and a counter-width constant function (clog2 of frame length).
REQ-029 One sub-module, sipo_bit_ctr (counter plus terminal-count flag), SHALL be used; all other logic SHALL stay flat.

Verification
REQ-030 With WIDTH=8 and LSB_FIRST=1, shifting bits 1,0,0,1,1,0,0,1 SHALL give q=8'h99 and valid=1 one cycle after the 8th edge.
REQ-031 Shifting bits 1,0,0,0,0,0,0,0 SHALL give q=8'h01 with LSB_FIRST=1 and q=8'h80 with LSB_FIRST=0.
REQ-032 With ready=0, two frames 8'h99 then 8'h0F SHALL give q=8'h0F, valid=1 and overrun=1; repeating with ready=1 on the second completion edge SHALL leave overrun=0.
REQ-033 clear after 3 bits, then a new 8-bit frame 8'hA5, SHALL give q=8'hA5 with busy=0 between frames; shift_en gaps of 0..5 cycles SHALL not alter the result.
REQ-034 rst_n pulsed low after 5 bits SHALL give all outputs 0 immediately; the next full frame 8'h3C SHALL decode correctly.
REQ-035 With SIPO_PARITY_EN, data 8'h99 with parity bit 1 SHALL give parity_err=1, and with parity bit 0 SHALL give parity_err=0.
